// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one internal control bus between the EBI host path (m0)
// and an internal req/ack master (m1). m0 always wins arbitration; a single m0
// strobe that arrives while the bus is occupied is parked in a 1-deep buffer.
//
// Handshakes:
//   m0: m0_we/m0_oe are single-cycle strobes with no backpressure. Reads are
//       answered with a 1-cycle m0_rvld pulse; writes get no response. A strobe
//       that finds the pending buffer full is lost and m0_ovf latches high.
//   m1: m1_req is a level held (with m1_wr/addr/wdata stable) until m1_ack
//       pulses for one cycle. Dropping m1_req before it is picked withdraws
//       the request; once picked, the access always completes.
module cbus_arbiter #(
  parameter int CBUS_ADDR_WIDTH = 8,
  parameter int CBUS_DATA_WIDTH = 16,
  parameter int RD_LAT          = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CBUS_ADDR_WIDTH-1:0] m0_addr,
  input  logic [CBUS_DATA_WIDTH-1:0] m0_wdata,
  input  logic                       m0_we,
  input  logic                       m0_oe,
  output logic [CBUS_DATA_WIDTH-1:0] m0_rdata,
  output logic                       m0_rvld,
  output logic                       m0_ovf,
  input  logic                       m1_req,
  input  logic                       m1_wr,
  input  logic [CBUS_ADDR_WIDTH-1:0] m1_addr,
  input  logic [CBUS_DATA_WIDTH-1:0] m1_wdata,
  output logic                       m1_ack,
  output logic [CBUS_DATA_WIDTH-1:0] m1_rdata,
  output logic [CBUS_ADDR_WIDTH-1:0] cbus_addr,
  output logic [CBUS_DATA_WIDTH-1:0] cbus_wdata,
  output logic                       cbus_we,
  output logic                       cbus_oe,
  input  logic [CBUS_DATA_WIDTH-1:0] cbus_rdata,
  output logic                       busy,
  output logic [1:0]                 o_dbg_state
);

  localparam int AW = CBUS_ADDR_WIDTH;
  localparam int DW = CBUS_DATA_WIDTH;
  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  // Current access: address/data live directly in the cbus output registers.
  logic [AW-1:0]   r_cbus_addr;
  logic [DW-1:0]   r_cbus_wdata;
  logic            r_cbus_we;
  logic            r_cbus_oe;
  logic            r_wr;
  logic            r_owner;     // 0 = m0, 1 = m1
  logic [2:0]      r_cnt;

  // 1-deep m0 pending buffer.
  logic            r_pend_vld;
  logic [AW-1:0]   r_pend_addr;
  logic [DW-1:0]   r_pend_wdata;
  logic            r_pend_wr;

  logic            r_ovf;
  logic [DW-1:0]   r_m0_rdata;
  logic [DW-1:0]   r_m1_rdata;

  // Arbitration results.
  logic            w_m0_stb;
  logic            w_pick;
  logic [AW-1:0]   w_lat_addr;
  logic [DW-1:0]   w_lat_wdata;
  logic            w_lat_wr;
  logic            w_lat_owner;
  logic            w_rd_done;

  // A simultaneous we+oe is treated as a write.
  assign w_m0_stb = m0_we | m0_oe;

  // Next-state and arbitration: pending m0, then new m0 strobe, then m1.
  always_comb begin
    w_next      = r_state;
    w_pick      = 1'b0;
    w_lat_addr  = r_cbus_addr;
    w_lat_wdata = r_cbus_wdata;
    w_lat_wr    = 1'b0;
    w_lat_owner = 1'b0;
    w_rd_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend_vld) begin
          w_pick      = 1'b1;
          w_lat_addr  = r_pend_addr;
          w_lat_wdata = r_pend_wdata;
          w_lat_wr    = r_pend_wr;
        end else if (w_m0_stb) begin
          w_pick      = 1'b1;
          w_lat_addr  = m0_addr;
          w_lat_wdata = m0_wdata;
          w_lat_wr    = m0_we;
        end else if (m1_req) begin
          w_pick      = 1'b1;
          w_lat_addr  = m1_addr;
          w_lat_wdata = m1_wdata;
          w_lat_wr    = m1_wr;
          w_lat_owner = 1'b1;
        end
        if (w_pick) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next = r_wr ? S_DONE : S_RDWAIT;
      end
      S_RDWAIT: begin
        // Counter reaches 1 in the cycle exactly RD_LAT cycles after ISSUE.
        if (r_cnt <= 3'd1) begin
          w_rd_done = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register, bus drive, read counter and read data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cbus_addr  <= '0;
      r_cbus_wdata <= '0;
      r_cbus_we    <= 1'b0;
      r_cbus_oe    <= 1'b0;
      r_wr         <= 1'b0;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_cbus_we <= 1'b0;
      r_cbus_oe <= 1'b0;
      if (w_pick) begin
        r_cbus_addr  <= w_lat_addr;
        r_cbus_wdata <= w_lat_wdata;
        r_cbus_we    <= w_lat_wr;
        r_cbus_oe    <= ~w_lat_wr;
        r_wr         <= w_lat_wr;
        r_owner      <= w_lat_owner;
      end
      if (r_state == S_ISSUE && !r_wr) begin
        r_cnt <= LAT;
      end else if (r_state == S_RDWAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_rd_done) begin
        if (r_owner) r_m1_rdata <= cbus_rdata;
        else         r_m0_rdata <= cbus_rdata;
      end
    end
  end

  // Pending buffer and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld   <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      r_pend_wr    <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        // The pending entry is consumed here; a new strobe in the same
        // cycle refills the freed slot instead of being lost.
        if (r_pend_vld) begin
          r_pend_vld <= w_m0_stb;
          if (w_m0_stb) begin
            r_pend_addr  <= m0_addr;
            r_pend_wdata <= m0_wdata;
            r_pend_wr    <= m0_we;
          end
        end
      end else if (w_m0_stb) begin
        if (!r_pend_vld) begin
          r_pend_vld   <= 1'b1;
          r_pend_addr  <= m0_addr;
          r_pend_wdata <= m0_wdata;
          r_pend_wr    <= m0_we;
        end else begin
          r_ovf <= 1'b1;
        end
      end
      if (m0_we && m0_oe) r_ovf <= 1'b1;
    end
  end

  assign cbus_addr   = r_cbus_addr;
  assign cbus_wdata  = r_cbus_wdata;
  assign cbus_we     = r_cbus_we;
  assign cbus_oe     = r_cbus_oe;
  assign m0_rdata    = r_m0_rdata;
  assign m0_rvld     = (r_state == S_DONE) && !r_owner && !r_wr;
  assign m0_ovf      = r_ovf;
  assign m1_ack      = (r_state == S_DONE) && r_owner;
  assign m1_rdata    = r_m1_rdata;
  assign busy        = (r_state != S_IDLE) || r_pend_vld;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed stimulus, a simple slave model returning
// fixed data per address after RD_LAT cycles, and a negedge monitor that pops
// expected bus accesses / m0 reads / m1 acks from queues.
module tb_cbus_arbiter;

  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_we;
  logic          m0_oe;
  logic [DW-1:0] m0_rdata;
  logic          m0_rvld;
  logic          m0_ovf;
  logic          m1_req;
  logic          m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] cbus_addr;
  logic [DW-1:0] cbus_wdata;
  logic          cbus_we;
  logic          cbus_oe;
  logic [DW-1:0] cbus_rdata;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  // Expected queues: bus {wr, addr, wdata}; m0 read data; m1 {is_read, data}.
  logic [AW+DW:0] bus_q[$];
  logic [DW-1:0]  m0_q[$];
  logic [DW:0]    m1_q[$];

  cbus_arbiter #(
    .CBUS_ADDR_WIDTH(AW),
    .CBUS_DATA_WIDTH(DW),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_oe(m0_oe),
    .m0_rdata(m0_rdata), .m0_rvld(m0_rvld), .m0_ovf(m0_ovf),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .cbus_addr(cbus_addr), .cbus_wdata(cbus_wdata), .cbus_we(cbus_we),
    .cbus_oe(cbus_oe), .cbus_rdata(cbus_rdata),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    case (a)
      8'h34:   rd_val = 16'h1234;
      8'h56:   rd_val = 16'hBEEF;
      8'h9A:   rd_val = 16'h5A5A;
      default: rd_val = {8'hC0, a};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic m0_strobe(input logic we, input logic oe, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    m0_we    = we;
    m0_oe    = oe;
    m0_addr  = a;
    m0_wdata = d;
  endtask

  task automatic m0_clear;
    m0_we = 1'b0;
    m0_oe = 1'b0;
  endtask

  task automatic m1_set(input logic req, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    m1_req   = req;
    m1_wr    = wr;
    m1_addr  = a;
    m1_wdata = d;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 50) begin
      tick;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // ---------------- slave model ----------------
  // Presents valid data only in the cycle RD_LAT cycles after the oe pulse.
  initial begin
    int s_cnt;
    logic [AW-1:0] s_addr;
    s_cnt = 0;
    s_addr = '0;
    cbus_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (cbus_oe) begin
        s_cnt  = RD_LAT;
        s_addr = cbus_addr;
      end
      @(posedge clk);
      #1;
      if (s_cnt > 0) begin
        s_cnt--;
        cbus_rdata = (s_cnt == 0) ? rd_val(s_addr) : 16'hDEAD;
      end else begin
        cbus_rdata = 16'hDEAD;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [AW+DW:0] eb;
    logic [DW:0]    e1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cbus_we || cbus_oe) begin
          if (bus_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_unexpected: got we=%0b oe=%0b addr=%0h expected no access",
                     cbus_we, cbus_oe, cbus_addr);
          end else begin
            eb = bus_q.pop_front();
            check("bus_dir", 32'({cbus_we, cbus_oe}), eb[AW+DW] ? 32'd2 : 32'd1);
            check("bus_addr", 32'(cbus_addr), 32'(eb[AW+DW-1:DW]));
            if (eb[AW+DW]) check("bus_wdata", 32'(cbus_wdata), 32'(eb[DW-1:0]));
          end
        end
        if (m0_rvld) begin
          if (m0_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL m0_rvld_unexpected: got rdata=%0h expected no rvld", m0_rdata);
          end else begin
            check("m0_rdata", 32'(m0_rdata), 32'(m0_q.pop_front()));
          end
        end
        if (m1_ack) begin
          ack_cnt++;
          if (m1_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL m1_ack_unexpected: got ack expected none");
          end else begin
            e1 = m1_q.pop_front();
            if (e1[DW]) check("m1_rdata", 32'(m1_rdata), 32'(e1[DW-1:0]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int ack_before;
    rst = 1'b1;
    m0_strobe(1'b0, 1'b0, '0, '0);
    m1_set(1'b0, 1'b0, '0, '0);
    repeat (3) tick;
    check("rst_strobes", 32'({cbus_we, cbus_oe, m0_rvld, m1_ack, m0_ovf, busy}), 32'd0);
    check("rst_cbus_addr", 32'(cbus_addr), 32'd0);
    check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    rst = 1'b0;
    tick;

    // 1: m0 write goes out one cycle after the strobe, no read response.
    m0_strobe(1'b1, 1'b0, 8'h12, 16'hA5A5);
    bus_q.push_back({1'b1, 8'h12, 16'hA5A5});
    tick;
    m0_clear;
    check("t1_we", 32'(cbus_we), 32'd1);
    check("t1_addr_data", 32'({cbus_addr, cbus_wdata}), 32'h0012A5A5);
    tick;
    check("t1_we_one_cycle", 32'(cbus_we), 32'd0);
    check("t1_no_rvld", 32'(m0_rvld), 32'd0);
    wait_idle;

    // 2: m0 read, data at ISSUE+2, rvld at T+4, rdata held afterwards.
    m0_strobe(1'b0, 1'b1, 8'h34, 16'h0000);
    bus_q.push_back({1'b0, 8'h34, 16'h0000});
    m0_q.push_back(16'h1234);
    tick;
    m0_clear;
    check("t2_oe", 32'(cbus_oe), 32'd1);
    tick;
    tick;
    check("t2_rvld_early", 32'(m0_rvld), 32'd0);
    tick;
    check("t2_rvld", 32'(m0_rvld), 32'd1);
    check("t2_rdata", 32'(m0_rdata), 32'h1234);
    tick;
    check("t2_rvld_pulse", 32'(m0_rvld), 32'd0);
    check("t2_rdata_held", 32'(m0_rdata), 32'h1234);
    wait_idle;

    // 3: m1 read and m0 write together; m0 first, m1 ack at T+7.
    m1_set(1'b1, 1'b0, 8'h56, 16'h0000);
    m0_strobe(1'b1, 1'b0, 8'h78, 16'h0F0F);
    bus_q.push_back({1'b1, 8'h78, 16'h0F0F});
    bus_q.push_back({1'b0, 8'h56, 16'h0000});
    m1_q.push_back({1'b1, 16'hBEEF});
    tick;
    m0_clear;
    check("t3_m0_first", 32'({cbus_we, cbus_addr}), 32'h178);
    n = 1;
    while (!m1_ack && n < 30) begin
      tick;
      n++;
    end
    m1_req = 1'b0;
    check("t3_ack_latency", 32'(n), 32'd7);
    check("t3_m1_rdata", 32'(m1_rdata), 32'hBEEF);
    wait_idle;

    // 4: m1 read in flight; first m0_oe buffered, second dropped.
    m1_set(1'b1, 1'b0, 8'h9A, 16'h0000);
    bus_q.push_back({1'b0, 8'h9A, 16'h0000});
    m1_q.push_back({1'b1, 16'h5A5A});
    bus_q.push_back({1'b0, 8'h3C, 16'h0000});
    m0_q.push_back(16'hC03C);
    tick;                                   // ISSUE
    tick;                                   // RDWAIT
    m0_strobe(1'b0, 1'b1, 8'h3C, 16'h0000);
    tick;                                   // RDWAIT
    m0_clear;
    check("t4_no_ovf_yet", 32'(m0_ovf), 32'd0);
    tick;                                   // DONE
    check("t4_m1_ack", 32'(m1_ack), 32'd1);
    m1_req = 1'b0;
    m0_strobe(1'b0, 1'b1, 8'h40, 16'h0000);
    tick;                                   // IDLE, picks pending
    m0_clear;
    check("t4_ovf", 32'(m0_ovf), 32'd1);
    check("t4_busy_pending", 32'(busy), 32'd1);
    tick;                                   // ISSUE of buffered read
    check("t4_pend_issue", 32'({cbus_oe, cbus_addr}), 32'h13C);
    n = 6;
    while (!m0_rvld && n < 40) begin
      tick;
      n++;
    end
    check("t4_rvld_latency", 32'(n), 32'd9);
    check("t4_rdata", 32'(m0_rdata), 32'hC03C);
    wait_idle;
    check("t4_ovf_sticky", 32'(m0_ovf), 32'd1);

    // 5: reset during RDWAIT aborts with no ack; a later m1 write works.
    m1_set(1'b1, 1'b0, 8'h56, 16'h0000);
    bus_q.push_back({1'b0, 8'h56, 16'h0000});
    tick;
    check("t5_oe", 32'(cbus_oe), 32'd1);
    tick;
    rst = 1'b1;
    m1_req = 1'b0;
    tick;
    check("t5_rst_strobes", 32'({cbus_we, cbus_oe, m0_rvld, m1_ack, m0_ovf, busy}), 32'd0);
    check("t5_rst_bus", 32'({cbus_addr, cbus_wdata}), 32'd0);
    check("t5_rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    rst = 1'b0;
    ack_before = ack_cnt;
    repeat (6) tick;
    check("t5_no_ack", 32'(ack_cnt), 32'(ack_before));
    m1_set(1'b1, 1'b1, 8'h21, 16'h7777);
    bus_q.push_back({1'b1, 8'h21, 16'h7777});
    m1_q.push_back({1'b0, 16'h0000});
    n = 0;
    while (!m1_ack && n < 30) begin
      tick;
      n++;
    end
    m1_req = 1'b0;
    check("t5_wr_ack_latency", 32'(n), 32'd2);
    wait_idle;

    // 6: 1-cycle m1_req pulse while m0 owns the bus is withdrawn.
    m0_strobe(1'b0, 1'b1, 8'h34, 16'h0000);
    bus_q.push_back({1'b0, 8'h34, 16'h0000});
    m0_q.push_back(16'h1234);
    ack_before = ack_cnt;
    tick;
    m0_clear;
    tick;
    m1_set(1'b1, 1'b0, 8'h66, 16'h0000);
    tick;
    m1_req = 1'b0;
    repeat (8) tick;
    check("t6_no_ack", 32'(ack_cnt), 32'(ack_before));

    // 7: we and oe together -> write plus overflow flag.
    check("t7_ovf_clear", 32'(m0_ovf), 32'd0);
    m0_strobe(1'b1, 1'b1, 8'h11, 16'h2222);
    bus_q.push_back({1'b1, 8'h11, 16'h2222});
    tick;
    m0_clear;
    check("t7_we_only", 32'({cbus_we, cbus_oe}), 32'd2);
    check("t7_ovf", 32'(m0_ovf), 32'd1);
    wait_idle;
    repeat (3) tick;

    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("m0_q_drained", 32'(m0_q.size()), 32'd0);
    check("m1_q_drained", 32'(m1_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
